// File: rtl/result_display.sv
// Sign + three-digit decimal display of the operation stage result.
// Double-dabble conversion feeds a 4-digit multiplexed seven-segment scan.
module result_display #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] value_in,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp,
   output logic        busy
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [6:0] digit_code(input logic [3:0] d);
      logic [6:0] c;
      c = SEG_BLANK;
      unique case (d)
         4'd0: c = 7'b1000000;
         4'd1: c = 7'b1111001;
         4'd2: c = 7'b0100100;
         4'd3: c = 7'b0110000;
         4'd4: c = 7'b0011001;
         4'd5: c = 7'b0010010;
         4'd6: c = 7'b0000010;
         4'd7: c = 7'b1111000;
         4'd8: c = 7'b0000000;
         4'd9: c = 7'b0010000;
         default: c = SEG_BLANK;
      endcase
      return c;
   endfunction

   logic [1:0]    state;
   logic [10:0]   last_val;
   logic          neg;
   logic [26:0]   sreg;
   logic [3:0]    iter;
   logic [6:0]    img [4];
   logic [CW-1:0] cnt;
   logic [1:0]    idx;

   logic [11:0]   mag;
   logic [26:0]   sreg_adj;
   logic [3:0]    bcd_th;
   logic [3:0]    bcd_h;
   logic [3:0]    bcd_t;
   logic [3:0]    bcd_u;
   logic          ovf;
   logic [6:0]    new_img [4];
   logic [6:0]    img_n [4];
   logic          wrap;
   logic [1:0]    idx_n;

   // 12-bit negate so that -1024 yields a magnitude of 1024
   always_comb begin
      mag = {last_val[10], last_val};
      if (last_val[10])
         mag = 12'd0 - {last_val[10], last_val};
   end

   always_comb begin
      sreg_adj = sreg;
      for (int n = 0; n < 4; n++) begin
         if (sreg[11 + 4*n +: 4] >= 4'd5)
            sreg_adj[11 + 4*n +: 4] = sreg[11 + 4*n +: 4] + 4'd3;
      end
   end

   assign bcd_th = sreg[26:23];
   assign bcd_h  = sreg[22:19];
   assign bcd_t  = sreg[18:15];
   assign bcd_u  = sreg[14:11];
   assign ovf    = (bcd_th != 4'd0);

   always_comb begin
      new_img[3] = neg ? SEG_DASH : SEG_BLANK;
      new_img[2] = (bcd_h == 4'd0) ? SEG_BLANK : digit_code(bcd_h);
      new_img[1] = ((bcd_h == 4'd0) && (bcd_t == 4'd0))
                   ? SEG_BLANK : digit_code(bcd_t);
      new_img[0] = digit_code(bcd_u);
      if (ovf) begin
         for (int n = 0; n < 4; n++)
            new_img[n] = SEG_DASH;
      end
   end

   // The outgoing seg follows the image being committed this cycle
   always_comb begin
      for (int n = 0; n < 4; n++)
         img_n[n] = (state == S_DONE) ? new_img[n] : img[n];
   end

   assign wrap  = (cnt == CNT_LAST);
   assign idx_n = wrap ? idx + 2'd1 : idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         last_val <= 11'd0;
         neg      <= 1'b0;
         sreg     <= 27'd0;
         iter     <= 4'd0;
         busy     <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (value_in != last_val) begin
                  last_val <= value_in;
                  busy     <= 1'b1;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               neg   <= last_val[10];
               sreg  <= {16'd0, mag[10:0]};
               iter  <= 4'd0;
               state <= S_SHIFT;
            end
            S_SHIFT: begin
               sreg <= {sreg_adj[25:0], 1'b0};
               iter <= iter + 4'd1;
               if (iter == 4'd10)
                  state <= S_DONE;
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         img[3] <= SEG_BLANK;
         img[2] <= SEG_BLANK;
         img[1] <= SEG_BLANK;
         img[0] <= SEG_ZERO;
      end else if (state == S_DONE) begin
         for (int n = 0; n < 4; n++)
            img[n] <= new_img[n];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= 2'd0;
         an  <= 4'b1110;
         seg <= SEG_ZERO;
      end else begin
         cnt <= wrap ? '0 : cnt + 1'b1;
         idx <= idx_n;
         an  <= ~(4'b0001 << idx_n);
         seg <= img_n[idx_n];
      end
   end

   assign dp = 1'b1;

endmodule

// File: tb/tb_result_display.sv
// Randomized self-checking bench for result_display.
// Expected digits come from integer arithmetic on the signed value.
module tb_result_display;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] value_in;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cur = 0;

   logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                            7'b0110000, 7'b0011001, 7'b0010010,
                            7'b0000010, 7'b1111000, 7'b0000000,
                            7'b0010000};
   localparam logic [6:0] DASH  = 7'b0111111;
   localparam logic [6:0] BLANK = 7'b1111111;

   result_display #(.REFRESH_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .value_in(value_in),
      .seg(seg), .an(an), .dp(dp), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] ref_digit(input int v, input int pos);
      int m, h, t, u;
      m = (v < 0) ? -v : v;
      if (m > 999) return DASH;
      h = m / 100;
      t = (m / 10) % 10;
      u = m % 10;
      case (pos)
         3: return (v < 0) ? DASH : BLANK;
         2: return (h == 0) ? BLANK : tbl[h];
         1: return (h == 0 && t == 0) ? BLANK : tbl[t];
         default: return tbl[u];
      endcase
   endfunction

   function automatic int an_idx(input logic [3:0] a);
      for (int i = 0; i < 4; i++)
         if (a == ~(4'b0001 << i)) return i;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cur(input string tag, input int v);
      int i;
      i = an_idx(an);
      check({tag, "_an"}, 32'(i >= 0), 32'd1);
      if (i >= 0) check({tag, "_seg"}, 32'(seg), 32'(ref_digit(v, i)));
   endtask

   task automatic capture(input string tag, input int v);
      for (int k = 0; k < 4 * DIV; k++) begin
         tick();
         check_cur(tag, v);
      end
      check({tag, "_dp"}, 32'(dp), 32'd1);
   endtask

   task automatic convert(input string tag, input int v);
      value_in = 11'(v);
      tick();
      check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      for (int k = 2; k <= 13; k++) tick();
      check_cur({tag, "_old"}, cur);
      check({tag, "_busy_hold"}, 32'(busy), 32'd1);
      tick();
      check({tag, "_busy_fall"}, 32'(busy), 32'd0);
      check_cur({tag, "_new"}, v);
      cur = v;
      capture(tag, v);
   endtask

   initial begin
      int dir [12] = '{123, -45, -999, -1024, 1000, 999,
                       -1, 9, 10, 99, 100, 1023};
      int v;
      int n;
      rst = 1'b1;
      value_in = 11'd0;
      tick();
      tick();
      check("rst_an", 32'(an), 32'hE);
      check("rst_seg", 32'(seg), 32'h40);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dp", 32'(dp), 32'd1);
      rst = 1'b0;

      for (int k = 1; k <= 4 * DIV; k++) begin
         tick();
         check("scan_an", 32'(an), 32'(~(4'b0001 << ((k / DIV) % 4)) & 4'hF));
         check("scan_seg", 32'(seg), 32'(ref_digit(0, (k / DIV) % 4)));
         check("scan_busy", 32'(busy), 32'd0);
      end

      foreach (dir[i]) convert($sformatf("dir%0d", dir[i]), dir[i]);

      // value changes during an ongoing conversion
      convert("pre7", 3);
      value_in = 11'd7;
      tick();
      tick();
      value_in = 11'd8;
      for (int k = 3; k <= 14; k++) tick();
      check_cur("race_first", 7);
      check("race_gap", 32'(busy), 32'd0);
      tick();
      check("race_restart", 32'(busy), 32'd1);
      for (int k = 16; k <= 27; k++) tick();
      check_cur("race_hold7", 7);
      tick();
      check_cur("race_second", 8);
      check("race_done", 32'(busy), 32'd0);
      cur = 8;
      capture("race_img", 8);

      // reset in the middle of SHIFT
      value_in = 11'd123;
      for (int k = 0; k < 5; k++) tick();
      check("mid_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      value_in = 11'd5;
      tick();
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_an", 32'(an), 32'hE);
      check("mid_rst_seg", 32'(seg), 32'h40);
      rst = 1'b0;
      n = 0;
      while (busy !== 1'b1 && n < 5) begin tick(); n++; end
      check("mid_restart_seen", 32'(busy), 32'd1);
      n = 0;
      while (busy !== 1'b0 && n < 30) begin tick(); n++; end
      check("mid_done_seen", 32'(busy), 32'd0);
      cur = 5;
      check_cur("mid_val", 5);
      capture("mid_img", 5);

      for (int r = 0; r < 24; r++) begin
         v = int'($signed(11'($urandom_range(0, 2047))));
         if (v == cur) v = (v == 0) ? 1 : 0;
         convert($sformatf("rnd%0d", v), v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
